inst_fetch: RTL and testbench

- Program-counter and fetch-control stage of the 3BC processor; drives the 11-bit instruction address into the instruction memory and sequences program execution.
- Handles Start/Done handshake with the testbench, sequential fetch, absolute jumps, PC-relative branches, stalls and halt.
- Sits directly upstream of instruction memory; decoder/control feeds its branch, jump, stall and halt inputs.

---
 rtl/inst_fetch.sv | 146 ++++++++++++++
 tb/tb_inst_fetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: program-counter and fetch-control stage of the 3BC processor.
//
// Sequences program execution through the IDLE -> RUN -> DONE states. It drives
// the instruction address into a combinational instruction memory. In RUN the
// PC is updated once per cycle with priority Halt > Stall > Jump > taken Branch
// > increment.
//
// Optional feature (macro INST_FETCH_BOUND_EN):
//   defined   - any RUN-state update that would wrap is suppressed. The PC holds,
//               Fault is raised and the state moves to DONE. An update wraps when
//               the PC increments from the top address, or when a relative branch
//               result falls outside 0..2**A_W-1. Jump never faults.
//   undefined - the PC wraps modulo 2**A_W and Fault stays 0.
//
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   synchronous active-high reset, wins over everything
//   Start        in   begin program at StartAddr (accepted in IDLE/DONE only)
//   StartAddr    in   [A_W-1:0] PC loaded on accepted Start
//   Stall        in   hold PC this cycle
//   Jump         in   absolute jump request
//   Target       in   [A_W-1:0] absolute jump destination
//   Branch       in   relative branch instruction present
//   Taken        in   branch condition true
//   Offset       in   [OFF_W-1:0] signed branch displacement
//   Halt         in   current instruction ends the program
//   InstAddress  out  [A_W-1:0] current PC (registered)
//   Running      out  high in RUN (registered)
//   Done         out  high in DONE (registered)
//   Fault        out  bound-check fault flag
//   CycleCount   out  [CNT_W-1:0] RUN cycles for current program, saturating

module inst_fetch #(
    parameter int unsigned A_W   = 11,
    parameter int unsigned OFF_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [A_W-1:0]   StartAddr,
    input  logic             Stall,
    input  logic             Jump,
    input  logic [A_W-1:0]   Target,
    input  logic             Branch,
    input  logic             Taken,
    input  logic [OFF_W-1:0] Offset,
    input  logic             Halt,
    output logic [A_W-1:0]   InstAddress,
    output logic             Running,
    output logic             Done,
    output logic             Fault,
    output logic [CNT_W-1:0] CycleCount
);

`ifdef INST_FETCH_BOUND_EN
    localparam bit BoundEn = 1'b1;
`else
    localparam bit BoundEn = 1'b0;
`endif

    localparam int unsigned EW = A_W + 2;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;
    state_t state;

    // Two guard bits above the PC. Bit A_W flags a carry past the top address.
    // Bit A_W+1 flags a negative branch result.
    logic [EW-1:0]    pc_ext;
    logic [EW-1:0]    off_ext;
    logic [EW-1:0]    inc_sum;
    logic [EW-1:0]    br_sum;
    logic             inc_fault;
    logic             br_fault;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        pc_ext    = {2'b00, InstAddress};
        off_ext   = {{(EW - OFF_W){Offset[OFF_W-1]}}, Offset};
        inc_sum   = pc_ext + EW'(1);
        br_sum    = pc_ext + off_ext;
        inc_fault = BoundEn && inc_sum[A_W];
        br_fault  = BoundEn && (br_sum[EW-1] || br_sum[A_W]);
        cnt_next  = (&CycleCount) ? CycleCount : CycleCount + CNT_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= StIdle;
            InstAddress <= '0;
            Running     <= 1'b0;
            Done        <= 1'b0;
            Fault       <= 1'b0;
            CycleCount  <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (Start) begin
                        state       <= StRun;
                        InstAddress <= StartAddr;
                        CycleCount  <= '0;
                        Running     <= 1'b1;
                        Done        <= 1'b0;
                        Fault       <= 1'b0;
                    end
                end
                StRun: begin
                    CycleCount <= cnt_next;
                    if (Halt) begin
                        state   <= StDone;
                        Running <= 1'b0;
                        Done    <= 1'b1;
                    end else if (Stall) begin
                        // PC holds
                    end else if (Jump) begin
                        InstAddress <= Target;
                    end else if (Branch && Taken) begin
                        if (br_fault) begin
                            state   <= StDone;
                            Running <= 1'b0;
                            Done    <= 1'b1;
                            Fault   <= 1'b1;
                        end else begin
                            InstAddress <= br_sum[A_W-1:0];
                        end
                    end else begin
                        if (inc_fault) begin
                            state   <= StDone;
                            Running <= 1'b0;
                            Done    <= 1'b1;
                            Fault   <= 1'b1;
                        end else begin
                            InstAddress <= inc_sum[A_W-1:0];
                        end
                    end
                end
                default: begin
                    state   <= StIdle;
                    Running <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch. It observes the packed status
// {Running, Done, Fault, CycleCount, InstAddress} 1 time unit after each
// rising edge.
module tb_inst_fetch;

    logic        Clk = 1'b0;
    logic        Reset, Start, Stall, Jump, Branch, Taken, Halt;
    logic [10:0] StartAddr, Target;
    logic [7:0]  Offset;
    logic [10:0] InstAddress;
    logic        Running, Done, Fault;
    logic [15:0] CycleCount;

    int n_cmp = 0;
    int n_fail = 0;
    logic [29:0] exp_st;
    logic [29:0] status;

    assign status = {Running, Done, Fault, CycleCount, InstAddress};

    inst_fetch dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .Jump(Jump), .Target(Target), .Branch(Branch),
        .Taken(Taken), .Offset(Offset), .Halt(Halt),
        .InstAddress(InstAddress), .Running(Running), .Done(Done),
        .Fault(Fault), .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    function automatic logic [29:0] st(input logic r, input logic d, input logic f,
                                       input logic [15:0] cc, input logic [10:0] pc);
        return {r, d, f, cc, pc};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_req();
        Start = 0; Stall = 0; Jump = 0; Branch = 0; Taken = 0; Halt = 0;
        Offset = '0; Target = '0;
    endtask

    // Brings the DUT to DONE if it is still running.
    task automatic end_prog();
        clear_req();
        if (Running) begin
            Halt = 1;
            tick();
            Halt = 0;
        end
    endtask

    task automatic start_prog(input logic [10:0] addr);
        clear_req();
        Start = 1; StartAddr = addr;
        tick();
        Start = 0;
    endtask

    task automatic test_reset();
        clear_req(); StartAddr = '0; Reset = 1;
        tick(); tick();
        exp_st = st(0, 0, 0, 16'd0, 11'h000); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL reset_state: got %h want %h", status, exp_st); end
        // Reset must win over Start.
        Start = 1; StartAddr = 11'h055;
        tick();
        n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL reset_over_start: got %h want %h", status, exp_st); end
        Reset = 0;
        start_prog(11'h010);
        tick(); tick();
        exp_st = st(1, 0, 0, 16'd2, 11'h012); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL run_before_reset: got %h want %h", status, exp_st); end
        Reset = 1;
        tick();
        Reset = 0;
        exp_st = st(0, 0, 0, 16'd0, 11'h000); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL reset_mid_run: got %h want %h", status, exp_st); end
        // In IDLE, requests other than Start are ignored.
        Jump = 1; Target = 11'h3AA; Halt = 1;
        tick();
        clear_req();
        n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL idle_ignores: got %h want %h", status, exp_st); end
    endtask

    task automatic test_sequential();
        start_prog(11'h100);
        exp_st = st(1, 0, 0, 16'd0, 11'h100); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL seq_start: got %h want %h", status, exp_st); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_st = st(1, 0, 0, 16'(i), 11'(11'h100 + i)); n_cmp++;
            if (status !== exp_st) begin n_fail++;
                $display("FAIL seq_step%0d: got %h want %h", i, status, exp_st); end
        end
        Halt = 1;
        tick();
        Halt = 0;
        exp_st = st(0, 1, 0, 16'd5, 11'h104); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL seq_halt: got %h want %h", status, exp_st); end
        tick(); tick();
        n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL done_hold: got %h want %h", status, exp_st); end
    endtask

    task automatic test_branch_jump();
        start_prog(11'h020);
        Branch = 1; Taken = 1; Offset = 8'hFC;
        tick();
        exp_st = st(1, 0, 0, 16'd1, 11'h01C); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL branch_minus4: got %h want %h", status, exp_st); end
        Taken = 0;
        tick();
        exp_st = st(1, 0, 0, 16'd2, 11'h01D); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL branch_not_taken: got %h want %h", status, exp_st); end
        Taken = 1; Jump = 1; Target = 11'h3FF;
        tick();
        exp_st = st(1, 0, 0, 16'd3, 11'h3FF); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL jump_over_branch: got %h want %h", status, exp_st); end
        clear_req();
        Jump = 1; Target = 11'h100;
        tick();
        clear_req();
        Branch = 1; Taken = 1; Offset = 8'h80;
        tick();
        exp_st = st(1, 0, 0, 16'd5, 11'h080); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL branch_minus128: got %h want %h", status, exp_st); end
        Offset = 8'h7F;
        tick();
        exp_st = st(1, 0, 0, 16'd6, 11'h0FF); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL branch_plus127: got %h want %h", status, exp_st); end
        clear_req();
        Jump = 1; Target = 11'h005;
        tick();
        clear_req();
        Branch = 1; Taken = 1; Offset = 8'hF8;
        tick();
        clear_req();
`ifdef INST_FETCH_BOUND_EN
        exp_st = st(0, 1, 1, 16'd8, 11'h005);
`else
        exp_st = st(1, 0, 0, 16'd8, 11'h7FD);
`endif
        n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL branch_neg_wrap: got %h want %h", status, exp_st); end
        end_prog();
    endtask

    task automatic test_stall();
        start_prog(11'h040);
        Stall = 1; Jump = 1; Target = 11'h123;
        tick();
        exp_st = st(1, 0, 0, 16'd1, 11'h040); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL stall_over_jump: got %h want %h", status, exp_st); end
        Jump = 0; Halt = 1;
        tick();
        clear_req();
        exp_st = st(0, 1, 0, 16'd2, 11'h040); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL halt_over_stall: got %h want %h", status, exp_st); end
    endtask

    task automatic test_wrap();
        start_prog(11'h7FF);
        tick();
`ifdef INST_FETCH_BOUND_EN
        exp_st = st(0, 1, 1, 16'd1, 11'h7FF);
`else
        exp_st = st(1, 0, 0, 16'd1, 11'h000);
`endif
        n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL inc_wrap: got %h want %h", status, exp_st); end
        end_prog();
        start_prog(11'h000);
        exp_st = st(1, 0, 0, 16'd0, 11'h000); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL start_clears_fault: got %h want %h", status, exp_st); end
    endtask

    task automatic test_back_to_back();
        // Running at 0x000 from the previous test; Start in RUN is ignored.
        Start = 1; StartAddr = 11'h300;
        tick();
        Start = 0;
        exp_st = st(1, 0, 0, 16'd1, 11'h001); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL start_in_run: got %h want %h", status, exp_st); end
        Halt = 1;
        tick();
        Halt = 0;
        exp_st = st(0, 1, 0, 16'd2, 11'h001); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL b2b_halt: got %h want %h", status, exp_st); end
        start_prog(11'h200);
        exp_st = st(1, 0, 0, 16'd0, 11'h200); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL b2b_restart: got %h want %h", status, exp_st); end
        tick();
        exp_st = st(1, 0, 0, 16'd1, 11'h201); n_cmp++;
        if (status !== exp_st) begin n_fail++;
            $display("FAIL b2b_step: got %h want %h", status, exp_st); end
    endtask

    initial begin
        Reset = 1;
        StartAddr = '0;
        clear_req();
        test_reset();
        test_sequential();
        test_branch_jump();
        test_stall();
        test_wrap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
